// File: rtl/associate.sv
// associate: trainable linear associator (one neuron). Forward: res = sum(weights[i] * args[i]).
//            Backward: fbk[i] = weights[i] * err; when en is high, weights[i] += (err * args[i]) >>> RATE.
// Latency:   one cycle per path. res_valid / fbk_valid rise on the edge that accepts arg / err.
// Backpressure: arg_ready = !res_valid and err_ready = !fbk_valid. Each path holds one item; outputs stay stable until taken.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   en                               learning enable, sampled on the err accept edge
//   arg_valid/arg_ready/arg_data     ARGD unsigned ARGW-bit arguments, element i at [i*ARGW +: ARGW]
//   res_valid/res_ready/res_data     signed RESW-bit weighted sum
//   err_valid/err_ready/err_data     signed ERRW-bit error
//   fbk_valid/fbk_ready/fbk_data     ARGD signed FBKW-bit feedback elements, one per argument
//
// Build option: define ASSOCIATE_SATURATE_EN to saturate every narrowing step (result, feedback,
// weight update) to the signed range of its target width. Leave it undefined for two's-complement wrap.
//
// The weights array has no reset, so values loaded before or during reset survive it.

module associate #(
    parameter int unsigned ARGW = 8,
    parameter int unsigned ARGD = 2,
    parameter int unsigned RESW = 16,
    parameter int unsigned ERRW = 16,
    parameter int unsigned FBKW = 16,
    parameter int unsigned WGTW = 16,
    parameter int unsigned RATE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   arg_valid,
    output logic                   arg_ready,
    input  logic [ARGD*ARGW-1:0]   arg_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [RESW-1:0]        res_data,
    input  logic                   err_valid,
    output logic                   err_ready,
    input  logic [ERRW-1:0]        err_data,
    output logic                   fbk_valid,
    input  logic                   fbk_ready,
    output logic [ARGD*FBKW-1:0]   fbk_data
);

    // Forward accumulator: each product fits in WGTW+ARGW bits, and the sum adds clog2(ARGD) bits.
    localparam int unsigned ACCW = WGTW + ARGW + $clog2(ARGD);
    // Width of the weight x error product.
    localparam int unsigned FPW  = WGTW + ERRW;
    // Weight update: err*arg needs ERRW+ARGW+1 bits, and adding the old weight needs one more bit.
    localparam int unsigned UPW  = ERRW + ARGW + 2;

    logic signed [WGTW-1:0] weights [ARGD];
    logic        [ARGW-1:0] args    [ARGD];

    logic arg_fire;
    logic err_fire;

    logic signed [ACCW-1:0] acc;
    logic        [RESW-1:0] res_next;
    logic signed [FPW-1:0]  fbk_prod;
    logic signed [UPW-1:0]  delta;
    logic [ARGD*FBKW-1:0]   fbk_next;
    logic signed [WGTW-1:0] wgt_next [ARGD];

    // Narrow a wide signed value to w bits. The result is returned sign-extended,
    // and the caller keeps the low w bits.
    function automatic logic signed [63:0] reduce(input logic signed [63:0] x,
                                                  input int unsigned     w);
`ifdef ASSOCIATE_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end else begin
            return x;
        end
`else
        return (x <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

    assign arg_ready = !res_valid;
    assign err_ready = !fbk_valid;
    assign arg_fire  = arg_valid && arg_ready;
    assign err_fire  = err_valid && err_ready;

    // The forward sum uses the incoming arguments and the current (pre-update) weights.
    always_comb begin
        acc = '0;
        for (int i = 0; i < ARGD; i++) begin
            acc = acc + ACCW'(weights[i]) * ACCW'($signed({1'b0, arg_data[i*ARGW +: ARGW]}));
        end
        res_next = RESW'(reduce(64'(acc), RESW));
    end

    // The backward path uses the latched args from earlier accepts. This gives the documented
    // ordering when an arg and an err are accepted in the same cycle.
    always_comb begin
        fbk_next = '0;
        fbk_prod = '0;
        delta    = '0;
        for (int i = 0; i < ARGD; i++) begin
            fbk_prod = FPW'(weights[i]) * FPW'($signed(err_data));
            fbk_next[i*FBKW +: FBKW] = FBKW'(reduce(64'(fbk_prod), FBKW));
            delta = (UPW'($signed(err_data)) * UPW'($signed({1'b0, args[i]}))) >>> RATE;
            wgt_next[i] = WGTW'(reduce(64'(UPW'(weights[i]) + delta), WGTW));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            fbk_valid <= 1'b0;
            fbk_data  <= '0;
            for (int i = 0; i < ARGD; i++) begin
                args[i] <= '0;
            end
        end else begin
            if (arg_fire) begin
                for (int i = 0; i < ARGD; i++) begin
                    args[i] <= arg_data[i*ARGW +: ARGW];
                end
                res_data  <= res_next;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (err_fire) begin
                fbk_data  <= fbk_next;
                fbk_valid <= 1'b1;
            end else if (fbk_valid && fbk_ready) begin
                fbk_valid <= 1'b0;
            end
        end
    end

    // The weights have no reset. Updates are blocked while rst_n is low, because err_ready
    // stays high during reset.
    always_ff @(posedge clk) begin
        if (rst_n && err_fire && en) begin
            for (int i = 0; i < ARGD; i++) begin
                weights[i] <= wgt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_associate.sv
// Directed testbench for associate with the default parameters (ARGW=8, ARGD=2, 16-bit
// signed data, RATE=1). Weights are preloaded through the DUT hierarchy.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.

module tb_associate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        arg_valid;
    logic        arg_ready;
    logic [15:0] arg_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        err_valid;
    logic        err_ready;
    logic [15:0] err_data;
    logic        fbk_valid;
    logic        fbk_ready;
    logic [31:0] fbk_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    associate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg_data  (arg_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .err_data  (err_data),
        .fbk_valid (fbk_valid),
        .fbk_ready (fbk_ready),
        .fbk_data  (fbk_data)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_w(input logic [15:0] w0, input logic [15:0] w1);
        dut.weights[0] = w0;
        dut.weights[1] = w1;
    endtask

    task automatic send_arg(input logic [15:0] a);
        int t = 0;
        while (!arg_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!arg_ready) begin
            n_checks++;
            $display("FAIL arg_ready_timeout: arg_ready=%0b required 1", arg_ready);
        end
        arg_valid = 1'b1;
        arg_data  = a;
        @(negedge clk);
        arg_valid = 1'b0;
    endtask

    task automatic send_err(input logic [15:0] e, input logic en_v);
        int t = 0;
        while (!err_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!err_ready) begin
            n_checks++;
            $display("FAIL err_ready_timeout: err_ready=%0b required 1", err_ready);
        end
        err_valid = 1'b1;
        err_data  = e;
        en        = en_v;
        @(negedge clk);
        err_valid = 1'b0;
        en        = 1'b0;
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic take_fbk();
        fbk_ready = 1'b1;
        @(negedge clk);
        fbk_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0;
        arg_valid = 1'b0; arg_data = '0; res_ready = 1'b0;
        err_valid = 1'b0; err_data = '0; fbk_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %0b required 0", res_valid); else n_pass++;
        n_checks++; if (fbk_valid !== 1'b0) $display("FAIL rst_fbk_valid: got %0b required 0", fbk_valid); else n_pass++;
        n_checks++; if (res_data !== 16'h0000) $display("FAIL rst_res_data: got %h required 0000", res_data); else n_pass++;
        n_checks++; if (fbk_data !== 32'h0) $display("FAIL rst_fbk_data: got %h required 00000000", fbk_data); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (arg_ready !== 1'b1) $display("FAIL rst_arg_ready: got %0b required 1", arg_ready); else n_pass++;
        n_checks++; if (err_ready !== 1'b1) $display("FAIL rst_err_ready: got %0b required 1", err_ready); else n_pass++;
    endtask

    task automatic test_forward_zero();
        set_w(16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)));
        send_arg(16'h0000);
        n_checks++; if (res_valid !== 1'b1) $display("FAIL fz_latency: res_valid=%0b required 1", res_valid); else n_pass++;
        n_checks++; if (arg_ready !== 1'b0) $display("FAIL fz_arg_ready: got %0b required 0", arg_ready); else n_pass++;
        n_checks++; if (res_data !== 16'h0000) $display("FAIL fz_res: got %h required 0000", res_data); else n_pass++;
        take_res();
        n_checks++; if (res_valid !== 1'b0) $display("FAIL fz_drain: res_valid=%0b required 0", res_valid); else n_pass++;
    endtask

    task automatic test_forward_value();
        set_w(16'h0003, 16'hfffe);
        send_arg(16'h0504);   // args {4, 5}: 3*4 - 2*5 = 2
        n_checks++; if (res_data !== 16'h0002) $display("FAIL fv_res: got %h required 0002", res_data); else n_pass++;
        take_res();
    endtask

    task automatic test_backward_zero();
        send_err(16'h0000, 1'b1);
        n_checks++; if (fbk_valid !== 1'b1) $display("FAIL bz_latency: fbk_valid=%0b required 1", fbk_valid); else n_pass++;
        n_checks++; if (err_ready !== 1'b0) $display("FAIL bz_err_ready: got %0b required 0", err_ready); else n_pass++;
        n_checks++; if (fbk_data !== 32'h0) $display("FAIL bz_fbk1: got %h required 00000000", fbk_data); else n_pass++;
        take_fbk();
        n_checks++; if (fbk_valid !== 1'b0) $display("FAIL bz_drain: fbk_valid=%0b required 0", fbk_valid); else n_pass++;
        send_err(16'h0000, 1'b1);
        n_checks++; if (fbk_data !== 32'h0) $display("FAIL bz_fbk2: got %h required 00000000", fbk_data); else n_pass++;
        take_fbk();
        n_checks++; if (dut.weights[0] !== 16'h0003) $display("FAIL bz_w0: got %h required 0003", dut.weights[0]); else n_pass++;
        n_checks++; if (dut.weights[1] !== 16'hfffe) $display("FAIL bz_w1: got %h required fffe", dut.weights[1]); else n_pass++;
    endtask

    task automatic test_feedback_no_learn();
        // weights {3,-2}, err 5 -> fbk {15,-10}; en=0 keeps the weights
        send_err(16'h0005, 1'b0);
        n_checks++; if (fbk_data !== 32'hfff6_000f) $display("FAIL fb_data: got %h required fff6000f", fbk_data); else n_pass++;
        take_fbk();
        n_checks++; if (dut.weights[0] !== 16'h0003) $display("FAIL fb_w0: got %h required 0003", dut.weights[0]); else n_pass++;
        n_checks++; if (dut.weights[1] !== 16'hfffe) $display("FAIL fb_w1: got %h required fffe", dut.weights[1]); else n_pass++;
    endtask

    task automatic test_learning();
        set_w(16'h0000, 16'h0000);
        send_arg(16'h00ff);
        n_checks++; if (res_data !== 16'h0000) $display("FAIL ln_res: got %h required 0000", res_data); else n_pass++;
        take_res();
        send_err(16'h0010, 1'b1);   // 16*255 >>> 1 = 2040
        n_checks++; if (fbk_data !== 32'h0) $display("FAIL ln_fbk: got %h required 00000000", fbk_data); else n_pass++;
        n_checks++; if (dut.weights[0] !== 16'h07f8) $display("FAIL ln_w0: got %h required 07f8", dut.weights[0]); else n_pass++;
        n_checks++; if (dut.weights[1] !== 16'h0000) $display("FAIL ln_w1: got %h required 0000", dut.weights[1]); else n_pass++;
        take_fbk();
    endtask

    task automatic test_negative_update();
        set_w(16'h0003, 16'hfffe);
        send_arg(16'h0310);   // args {16, 3}: 48 - 6 = 42
        n_checks++; if (res_data !== 16'h002a) $display("FAIL neg_res: got %h required 002a", res_data); else n_pass++;
        take_res();
        send_err(16'hfffc, 1'b1);   // err -4
        n_checks++; if (fbk_data !== 32'h0008_fff4) $display("FAIL neg_fbk: got %h required 0008fff4", fbk_data); else n_pass++;
        n_checks++; if (dut.weights[0] !== 16'hffe3) $display("FAIL neg_w0: got %h required ffe3", dut.weights[0]); else n_pass++;
        n_checks++; if (dut.weights[1] !== 16'hfff8) $display("FAIL neg_w1: got %h required fff8", dut.weights[1]); else n_pass++;
        take_fbk();
    endtask

    task automatic test_simultaneous();
        set_w(16'h0001, 16'h0001);
        send_arg(16'h0002);
        take_res();
        arg_valid = 1'b1; arg_data = 16'h000a;
        err_valid = 1'b1; err_data = 16'h0001; en = 1'b1;
        @(negedge clk);
        arg_valid = 1'b0; err_valid = 1'b0; en = 1'b0;
        n_checks++; if (res_data !== 16'h000a) $display("FAIL sim_res: got %h required 000a", res_data); else n_pass++;
        n_checks++; if (fbk_data !== 32'h0001_0001) $display("FAIL sim_fbk: got %h required 00010001", fbk_data); else n_pass++;
        n_checks++; if (dut.weights[0] !== 16'h0002) $display("FAIL sim_w0: got %h required 0002", dut.weights[0]); else n_pass++;
        n_checks++; if (dut.weights[1] !== 16'h0001) $display("FAIL sim_w1: got %h required 0001", dut.weights[1]); else n_pass++;
        res_ready = 1'b1; fbk_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; fbk_ready = 1'b0;
        n_checks++; if ({res_valid, fbk_valid} !== 2'b00) $display("FAIL sim_drain: valids=%b required 00", {res_valid, fbk_valid}); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [15:0] exp_res;
        logic [31:0] exp_fbk;
`ifdef ASSOCIATE_SATURATE_EN
        exp_res = 16'h7fff;
        exp_fbk = 32'h7fff_7fff;
`else
        exp_res = 16'hfe02;
        exp_fbk = 32'h0001_0001;
`endif
        set_w(16'h7fff, 16'h7fff);
        send_arg(16'hffff);
        n_checks++; if (res_data !== exp_res) $display("FAIL sat_res: got %h required %h", res_data, exp_res); else n_pass++;
        take_res();
        send_err(16'h7fff, 1'b0);
        n_checks++; if (fbk_data !== exp_fbk) $display("FAIL sat_fbk: got %h required %h", fbk_data, exp_fbk); else n_pass++;
        take_fbk();
    endtask

    task automatic test_backpressure_reset();
        set_w(16'h0003, 16'hfffe);
        send_arg(16'h0504);
        arg_valid = 1'b1; arg_data = 16'h0101;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (arg_ready !== 1'b0) $display("FAIL bp_arg_ready[%0d]: got %0b required 0", k, arg_ready); else n_pass++;
            n_checks++; if (res_data !== 16'h0002) $display("FAIL bp_res_stable[%0d]: got %h required 0002", k, res_data); else n_pass++;
        end
        arg_valid = 1'b0;
        send_err(16'h0005, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if ({res_valid, fbk_valid} !== 2'b00) $display("FAIL rst_mid_valids: got %b required 00", {res_valid, fbk_valid}); else n_pass++;
        n_checks++; if (res_data !== 16'h0000) $display("FAIL rst_mid_res: got %h required 0000", res_data); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({arg_ready, err_ready} !== 2'b11) $display("FAIL rst_mid_ready: got %b required 11", {arg_ready, err_ready}); else n_pass++;
        n_checks++; if (dut.weights[0] !== 16'h0003) $display("FAIL rst_keep_w0: got %h required 0003", dut.weights[0]); else n_pass++;
        n_checks++; if (dut.weights[1] !== 16'hfffe) $display("FAIL rst_keep_w1: got %h required fffe", dut.weights[1]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_forward_zero();
        test_forward_value();
        test_backward_zero();
        test_feedback_no_learn();
        test_learning();
        test_negative_update();
        test_simultaneous();
        test_saturation();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
